// File: rtl/pa_dcache_pkg.sv
// rtl/pa_dcache_pkg.sv - shared geometry, FSM encoding and byte-enable helper for the dcache data path
package pa_dcache_pkg;

  localparam int IDX_WIDTH  = 12;
  localparam int LINE_WORDS = 4;
  localparam int OFF_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WB     = 2'd2
  } dc_state_e;

  // Byte enables (active-high) to per-bit array write enables (active-low)
  function automatic logic [31:0] be_to_wen(input logic [3:0] be);
    logic [31:0] wen;
    for (int i = 0; i < 4; i++) begin
      wen[8*i +: 8] = {8{~be[i]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/pa_dcache_wb_buf.sv
// rtl/pa_dcache_wb_buf.sv - one-entry valid/ready output buffer for write-back words
module pa_dcache_wb_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  logic          r_full;
  logic [DW-1:0] r_data;

  // Arriving array data is presented directly; it is only parked in r_data
  // when the consumer stalls, since the array does not hold dout for us.
  // The issuer never launches a read while a word is parked, so i_vld and
  // r_full are never both set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_vld && !i_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (r_full && i_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_vld  = r_full | i_vld;
  assign o_data = r_full ? r_data : (i_vld ? i_data : '0);

endmodule

// File: rtl/pa_dcache_data_ctrl.sv
// rtl/pa_dcache_data_ctrl.sv - dcache data SRAM port owner: load/store/refill/write-back arbitration
module pa_dcache_data_ctrl #(
  parameter int IDX_WIDTH  = pa_dcache_pkg::IDX_WIDTH,
  parameter int LINE_WORDS = pa_dcache_pkg::LINE_WORDS,
  parameter int OFF_WIDTH  = pa_dcache_pkg::OFF_WIDTH
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 ld_req,
  input  logic [IDX_WIDTH-1:0] ld_idx,
  output logic                 ld_grant,
  output logic                 ld_rdata_vld,
  output logic [31:0]          ld_rdata,
  input  logic                 st_req,
  input  logic [IDX_WIDTH-1:0] st_idx,
  input  logic [3:0]           st_be,
  input  logic [31:0]          st_data,
  output logic                 st_grant,
  input  logic                 rf_start,
  input  logic [IDX_WIDTH-1:0] rf_idx,
  input  logic                 rf_vld,
  input  logic [31:0]          rf_data,
  output logic                 rf_done,
  input  logic                 wb_start,
  input  logic [IDX_WIDTH-1:0] wb_idx,
  output logic                 wb_vld,
  output logic [31:0]          wb_data,
  output logic                 wb_last,
  input  logic                 wb_ready,
  output logic                 busy,
  output logic                 data_clk_en,
  output logic                 data_cen,
  output logic                 data_gwen,
  output logic [31:0]          data_wen,
  output logic [31:0]          data_din,
  output logic [IDX_WIDTH-1:0] data_idx,
  input  logic [31:0]          data_dout
);

  import pa_dcache_pkg::*;

  localparam int                 BASE_W   = IDX_WIDTH - OFF_WIDTH;
  localparam logic [OFF_WIDTH-1:0] LAST_OFF = OFF_WIDTH'(LINE_WORDS - 1);

  dc_state_e           r_state;
  dc_state_e           w_next_state;
  logic [OFF_WIDTH-1:0] r_rf_cnt;
  logic [OFF_WIDTH:0]   r_rd_cnt;
  logic [OFF_WIDTH-1:0] r_out_cnt;
  logic [BASE_W-1:0]    r_rf_base;
  logic [BASE_W-1:0]    r_wb_base;
  logic                 r_ld_pend;
  logic                 r_wb_pend;

  logic        w_rf_accept;
  logic        w_wb_accept;
  logic        w_rf_write;
  logic        w_wb_issue;
  logic        w_wb_hs;
  logic        w_buf_vld;
  logic [31:0] w_buf_data;
  logic        w_unused_idx_lsb;

  // Line bases drop the word offset; the offset bits of the request are don't-care.
  assign w_unused_idx_lsb = ^{rf_idx[OFF_WIDTH-1:0], wb_idx[OFF_WIDTH-1:0]};

  assign w_wb_hs = wb_vld & wb_ready;

  // Arbitration and array drive: one access per cycle, everything idle under reset
  always_comb begin
    w_next_state = r_state;
    ld_grant     = 1'b0;
    st_grant     = 1'b0;
    rf_done      = 1'b0;
    w_rf_accept  = 1'b0;
    w_wb_accept  = 1'b0;
    w_rf_write   = 1'b0;
    w_wb_issue   = 1'b0;
    data_cen     = 1'b1;
    data_gwen    = 1'b1;
    data_wen     = '1;
    data_din     = '0;
    data_idx     = '0;
    if (!cpurst) begin
      case (r_state)
        ST_IDLE: begin
          if (rf_start) begin
            w_rf_accept  = 1'b1;
            w_next_state = ST_REFILL;
          end else if (wb_start) begin
            w_wb_accept  = 1'b1;
            w_next_state = ST_WB;
          end else if (st_req) begin
            st_grant  = 1'b1;
            data_cen  = 1'b0;
            data_gwen = 1'b0;
            data_wen  = be_to_wen(st_be);
            data_din  = st_data;
            data_idx  = st_idx;
          end else if (ld_req) begin
            ld_grant = 1'b1;
            data_cen = 1'b0;
            data_idx = ld_idx;
          end
        end
        ST_REFILL: begin
          if (rf_vld) begin
            w_rf_write = 1'b1;
            data_cen   = 1'b0;
            data_gwen  = 1'b0;
            data_wen   = '0;
            data_din   = rf_data;
            data_idx   = {r_rf_base, r_rf_cnt};
            if (r_rf_cnt == LAST_OFF) begin
              rf_done      = 1'b1;
              w_next_state = ST_IDLE;
            end
          end
        end
        ST_WB: begin
          // MSB of r_rd_cnt set means all LINE_WORDS reads have issued
          w_wb_issue = !r_rd_cnt[OFF_WIDTH] && (!wb_vld || wb_ready);
          if (w_wb_issue) begin
            data_cen = 1'b0;
            data_idx = {r_wb_base, r_rd_cnt[OFF_WIDTH-1:0]};
          end
          if (w_wb_hs && (r_out_cnt == LAST_OFF)) begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State, counters, line bases and read-return tags
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state   <= ST_IDLE;
      r_rf_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_rf_base <= '0;
      r_wb_base <= '0;
      r_ld_pend <= 1'b0;
      r_wb_pend <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ld_pend <= ld_grant;
      r_wb_pend <= w_wb_issue;
      if (w_rf_accept) begin
        r_rf_base <= rf_idx[IDX_WIDTH-1:OFF_WIDTH];
        r_rf_cnt  <= '0;
      end else if (w_rf_write) begin
        r_rf_cnt <= r_rf_cnt + 1'b1;
      end
      if (w_wb_accept) begin
        r_wb_base <= wb_idx[IDX_WIDTH-1:OFF_WIDTH];
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_wb_issue) r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_wb_hs)    r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  pa_dcache_wb_buf #(.DW(32)) u_wb_buf (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .i_vld   (r_wb_pend),
    .i_data  (data_dout),
    .i_ready (wb_ready),
    .o_vld   (w_buf_vld),
    .o_data  (w_buf_data)
  );

  assign wb_vld       = w_buf_vld & ~cpurst;
  assign wb_data      = wb_vld ? w_buf_data : '0;
  assign wb_last      = wb_vld && (r_out_cnt == LAST_OFF);
  assign ld_rdata_vld = r_ld_pend & ~cpurst;
  assign ld_rdata     = ld_rdata_vld ? data_dout : '0;
  assign busy         = (r_state != ST_IDLE) & ~cpurst;
  assign data_clk_en  = ~data_cen;

endmodule

// File: tb/tb_pa_dcache_data_ctrl.sv
// tb/tb_pa_dcache_data_ctrl.sv - scoreboard bench for pa_dcache_data_ctrl with a behavioural data array
module tb_pa_dcache_data_ctrl;

  logic        clk;
  logic        cpurst;
  logic        ld_req;
  logic [11:0] ld_idx;
  logic        ld_grant, ld_rdata_vld;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [11:0] st_idx;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        st_grant;
  logic        rf_start, rf_vld, rf_done;
  logic [11:0] rf_idx;
  logic [31:0] rf_data;
  logic        wb_start, wb_vld, wb_last, wb_ready;
  logic [11:0] wb_idx;
  logic [31:0] wb_data;
  logic        busy, data_clk_en, data_cen, data_gwen;
  logic [31:0] data_wen, data_din, data_dout;
  logic [11:0] data_idx;

  typedef struct { logic [11:0] idx; logic [31:0] wen; logic [31:0] din; } wr_t;
  typedef struct { logic [31:0] data; logic last; } wb_t;

  logic [31:0] ld_q [$];
  wb_t         wb_q [$];
  wr_t         wr_q [$];

  int vectors = 0;
  int miscompares = 0;
  int rd_count = 0;

  pa_dcache_data_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .ld_req         (ld_req),
    .ld_idx         (ld_idx),
    .ld_grant       (ld_grant),
    .ld_rdata_vld   (ld_rdata_vld),
    .ld_rdata       (ld_rdata),
    .st_req         (st_req),
    .st_idx         (st_idx),
    .st_be          (st_be),
    .st_data        (st_data),
    .st_grant       (st_grant),
    .rf_start       (rf_start),
    .rf_idx         (rf_idx),
    .rf_vld         (rf_vld),
    .rf_data        (rf_data),
    .rf_done        (rf_done),
    .wb_start       (wb_start),
    .wb_idx         (wb_idx),
    .wb_vld         (wb_vld),
    .wb_data        (wb_data),
    .wb_last        (wb_last),
    .wb_ready       (wb_ready),
    .busy           (busy),
    .data_clk_en    (data_clk_en),
    .data_cen       (data_cen),
    .data_gwen      (data_gwen),
    .data_wen       (data_wen),
    .data_din       (data_din),
    .data_idx       (data_idx),
    .data_dout      (data_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [11:0] idx);
    return 32'h5A00_0000 | {20'h0, idx};
  endfunction

  // Behavioural array: registered dout, garbage when not read so stale data shows up
  logic [31:0] mem [0:4095];
  logic        mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(12'(i));
      mem_init_done <= 1'b1;
      data_dout <= 32'hDEAD_BEEF;
    end else if (!data_cen && !data_gwen) begin
      mem[data_idx] <= (mem[data_idx] & data_wen) | (data_din & ~data_wen);
      data_dout <= 32'hDEAD_BEEF;
    end else if (!data_cen) begin
      data_dout <= mem[data_idx];
    end else begin
      data_dout <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents data or an array write
  always @(negedge clk) begin
    if (!cpurst) begin
      chk("clk_en", data_clk_en, 1'(~data_cen));
      chk("grant_excl", ld_grant & st_grant, 0);
      if (!data_cen && data_gwen) rd_count++;
      if (ld_rdata_vld) begin
        if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
        else begin
          logic [31:0] e;
          e = ld_q.pop_front();
          chk("ld_rdata", ld_rdata, e);
        end
      end
      if (wb_vld && wb_ready) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_data", wb_data, w.data);
          chk("wb_last", wb_last, w.last);
        end
      end
      if (!data_cen && !data_gwen) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_idx", data_idx, w.idx);
          chk("wr_wen", data_wen, w.wen);
          chk("wr_din", data_din, w.din);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push_wr(input logic [11:0] idx, input logic [31:0] wen, input logic [31:0] din);
    wr_t w;
    w.idx = idx; w.wen = wen; w.din = din;
    wr_q.push_back(w);
  endtask

  task automatic push_wb(input logic [31:0] data, input logic last);
    wb_t w;
    w.data = data; w.last = last;
    wb_q.push_back(w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    cpurst = 1'b1; ld_req = 1'b1; st_req = 1'b1; ld_idx = '0; st_idx = '0;
    st_be = 4'hF; st_data = '0; rf_start = 1'b0; rf_idx = '0; rf_vld = 1'b0;
    rf_data = '0; wb_start = 1'b0; wb_idx = '0; wb_ready = 1'b1;

    // Reset state with requests asserted
    repeat (3) tick();
    settle();
    chk("rst_ld_grant", ld_grant, 0);
    chk("rst_st_grant", st_grant, 0);
    chk("rst_cen", data_cen, 1);
    chk("rst_gwen", data_gwen, 1);
    chk("rst_wen", data_wen, 32'hFFFF_FFFF);
    chk("rst_busy", busy, 0);
    chk("rst_ld_vld", ld_rdata_vld, 0);
    chk("rst_ld_rdata", ld_rdata, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_rf_done", rf_done, 0);
    chk("rst_clk_en", data_clk_en, 0);
    tick();
    cpurst = 1'b0; ld_req = 1'b0; st_req = 1'b0;

    // Partial store then load back
    tick();
    st_req = 1'b1; st_idx = 12'h010; st_be = 4'b0101; st_data = 32'hAABB_CCDD;
    push_wr(12'h010, 32'hFF00_FF00, 32'hAABB_CCDD);
    settle();
    chk("st_grant", st_grant, 1);
    chk("st_gwen", data_gwen, 0);
    chk("st_wen", data_wen, 32'hFF00_FF00);
    tick();
    st_req = 1'b0; ld_req = 1'b1; ld_idx = 12'h010;
    ld_q.push_back(32'h5ABB_00DD);
    settle();
    chk("ld_grant", ld_grant, 1);
    tick();
    ld_req = 1'b0;
    settle();
    chk("ld_vld_next", ld_rdata_vld, 1);

    // Simultaneous store and load: store wins, load follows
    tick();
    st_req = 1'b1; st_idx = 12'h020; st_be = 4'hF; st_data = 32'h1234_5678;
    ld_req = 1'b1; ld_idx = 12'h020;
    push_wr(12'h020, 32'h0, 32'h1234_5678);
    settle();
    chk("arb_st_first", st_grant, 1);
    chk("arb_ld_held", ld_grant, 0);
    tick();
    st_req = 1'b0;
    ld_q.push_back(32'h1234_5678);
    settle();
    chk("arb_ld_second", ld_grant, 1);
    // Zero byte enables still take the slot but write nothing
    tick();
    ld_req = 1'b0; st_req = 1'b1; st_idx = 12'h021; st_be = 4'h0; st_data = 32'hFFFF_FFFF;
    push_wr(12'h021, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    settle();
    chk("st_be0_grant", st_grant, 1);
    tick();
    st_req = 1'b0; ld_req = 1'b1; ld_idx = 12'h021;
    ld_q.push_back(init_word(12'h021));
    tick();
    ld_req = 1'b0;

    // Refill with a bubble while a load waits
    tick();
    rf_start = 1'b1; rf_idx = 12'h123; ld_req = 1'b1; ld_idx = 12'h120;
    settle();
    chk("rf_start_no_acc", data_cen, 1);
    chk("rf_start_no_grant", ld_grant, 0);
    tick();
    rf_start = 1'b0; rf_vld = 1'b1; rf_data = 32'h11;
    push_wr(12'h120, 32'h0, 32'h11);
    settle();
    chk("rf_busy", busy, 1);
    chk("rf_ld_blocked", ld_grant, 0);
    chk("rf_done_early", rf_done, 0);
    tick();
    rf_vld = 1'b0;
    settle();
    chk("rf_bubble", data_cen, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      rf_vld = 1'b1; rf_data = 32'h22 + 32'(k) * 32'h11;
      push_wr(12'h121 + 12'(k), 32'h0, 32'h22 + 32'(k) * 32'h11);
      settle();
      chk("rf_done", rf_done, (k == 2));
      chk("rf_ld_blocked", ld_grant, 0);
    end
    tick();
    rf_vld = 1'b0;
    ld_q.push_back(32'h11);
    settle();
    chk("rf_after_busy", busy, 0);
    chk("rf_after_ld_grant", ld_grant, 1);
    tick();
    ld_req = 1'b0;

    // Write-back at full throughput
    tick();
    wb_start = 1'b1; wb_idx = 12'h040; wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) push_wb(init_word(12'h040 + 12'(k)), (k == 3));
    r0 = rd_count;
    tick();
    wb_start = 1'b0;
    settle();
    chk("wb_first_gap", wb_vld, 0);
    chk("wb_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      settle();
      chk("wb_stream_vld", wb_vld, 1);
      chk("wb_stream_last", wb_last, (k == 3));
    end
    tick();
    settle();
    chk("wb_end_vld", wb_vld, 0);
    chk("wb_end_busy", busy, 0);
    chk("wb_reads", rd_count - r0, 4);

    // Write-back with a 3-cycle stall on word 1; offset bits of wb_idx ignored
    tick();
    wb_start = 1'b1; wb_idx = 12'h043;
    for (int k = 0; k < 4; k++) push_wb(init_word(12'h040 + 12'(k)), (k == 3));
    r0 = rd_count;
    tick();
    wb_start = 1'b0;
    tick();
    settle();
    chk("wbs_word0_vld", wb_vld, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      wb_ready = 1'b0;
      settle();
      chk("wbs_stall_vld", wb_vld, 1);
      chk("wbs_stall_data", wb_data, init_word(12'h041));
    end
    tick();
    wb_ready = 1'b1;
    settle();
    chk("wbs_release_data", wb_data, init_word(12'h041));
    tick();
    tick();
    settle();
    chk("wbs_last", wb_last, 1);
    tick();
    settle();
    chk("wbs_end_busy", busy, 0);
    chk("wbs_reads", rd_count - r0, 4);

    // Reset in the middle of a refill, then a fresh refill
    tick();
    rf_start = 1'b1; rf_idx = 12'h201;
    tick();
    rf_start = 1'b0; rf_vld = 1'b1; rf_data = 32'hA1;
    push_wr(12'h200, 32'h0, 32'hA1);
    tick();
    rf_data = 32'hA2;
    push_wr(12'h201, 32'h0, 32'hA2);
    tick();
    rf_vld = 1'b0; cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    settle();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cen", data_cen, 1);
    tick();
    rf_start = 1'b1; rf_idx = 12'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      rf_start = 1'b0; rf_vld = 1'b1; rf_data = 32'hB1 + 32'(k);
      push_wr(12'h200 + 12'(k), 32'h0, 32'hB1 + 32'(k));
      settle();
      chk("rf2_done", rf_done, (k == 3));
    end
    tick();
    rf_vld = 1'b0; ld_req = 1'b1; ld_idx = 12'h201;
    ld_q.push_back(32'hB2);
    tick();
    ld_req = 1'b0;
    tick();

    // Back-to-back loads
    for (int k = 0; k < 3; k++) begin
      tick();
      ld_req = 1'b1; ld_idx = 12'(k);
      ld_q.push_back(init_word(12'(k)));
      settle();
      chk("b2b_grant", ld_grant, 1);
      chk("b2b_vld", ld_rdata_vld, (k != 0));
    end
    tick();
    ld_req = 1'b0;
    settle();
    chk("b2b_vld_tail", ld_rdata_vld, 1);
    tick();
    settle();
    chk("b2b_vld_off", ld_rdata_vld, 0);

    tick();
    tick();
    chk("ld_q_drained", ld_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
